// File: rtl/fft_stream_out.sv
// Frame serializer: snapshots one parallel FFT result frame on an accepted start
// and drains it as an AXI-Stream, LANES bins per beat, natural or bit-reversed order.
module fft_stream_out #(
  parameter int FFT_SIZE     = 8,
  parameter int FFT_SIZE_LOG = 3,
  parameter int WIDTH        = 18,
  parameter int LANES        = 1,
  parameter int BIT_REVERSE  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [FFT_SIZE*WIDTH-1:0]   data_in_R,
  input  logic [FFT_SIZE*WIDTH-1:0]   data_in_I,
  output logic                        ready,
  input  logic                        dma_tready,
  output logic                        dma_tvalid,
  output logic                        dma_tlast,
  output logic [LANES*2*WIDTH-1:0]    dma_tdata,
  output logic                        frame_done,
  output logic                        err_start
);

  localparam int BEATS   = FFT_SIZE / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FRAME_W = FFT_SIZE * WIDTH;
  localparam int BEAT_DW = LANES * 2 * WIDTH;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] PENULT_BEAT = BEAT_W'(BEATS - 2);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic [FRAME_W-1:0]  snap_re_p0, snap_im_p0;
  logic                start_held;
  logic                accept, hs, last_hs;

  function automatic int bitrev(input int idx);
    int r;
    r = 0;
    for (int n = 0; n < FFT_SIZE_LOG; n++)
      r = r | (((idx >> n) & 1) << (FFT_SIZE_LOG - 1 - n));
    return r;
  endfunction

  // Gathers the LANES bins of beat b from a packed frame into one {I, R} lane word each.
  function automatic logic [BEAT_DW-1:0] pack_beat(input logic [FRAME_W-1:0] re,
                                                   input logic [FRAME_W-1:0] im,
                                                   input logic [BEAT_W-1:0]  b);
    logic [BEAT_DW-1:0] d;
    int j;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      j = int'(b) * LANES + k;
      if (BIT_REVERSE != 0) j = bitrev(j);
      d[k*2*WIDTH +: 2*WIDTH] = {im[j*WIDTH +: WIDTH], re[j*WIDTH +: WIDTH]};
    end
    return d;
  endfunction

  assign ready   = (state == IDLE);
  assign accept  = start && ready;
  assign hs      = dma_tvalid && dma_tready;
  assign last_hs = hs && (beat == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = SEND;
      SEND:    if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, beat counter and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_re_p0 <= '0;
      snap_im_p0 <= '0;
      beat       <= '0;
      dma_tvalid <= 1'b0;
      dma_tlast  <= 1'b0;
      dma_tdata  <= '0;
      frame_done <= 1'b0;
      err_start  <= 1'b0;
      start_held <= 1'b0;
    end else begin
      frame_done <= last_hs;
      start_held <= accept || (start_held && start);
      // A level start kept high since acceptance is legal; only a fresh request while busy is an error.
      if (start && !ready && !start_held) err_start <= 1'b1;
      if (accept) begin
        snap_re_p0 <= data_in_R;
        snap_im_p0 <= data_in_I;
        beat       <= '0;
        dma_tvalid <= 1'b1;
        dma_tlast  <= (BEATS == 1);
        dma_tdata  <= pack_beat(data_in_R, data_in_I, '0);
      end else if (hs) begin
        if (beat == LAST_BEAT) begin
          dma_tvalid <= 1'b0;
          dma_tlast  <= 1'b0;
          dma_tdata  <= '0;
        end else begin
          beat       <= beat + 1'b1;
          dma_tlast  <= (beat == PENULT_BEAT);
          dma_tdata  <= pack_beat(snap_re_p0, snap_im_p0, beat + 1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_stream_out.sv
// Bench for fft_stream_out: several lane/order configurations driven by shared random
// stimulus, each compared every cycle against a frame-level behavioural model.
module tb_fft_stream_out;

  localparam int FFT_SIZE = 8;
  localparam int LOG      = 3;
  localparam int WIDTH    = 18;
  localparam int NI       = 5;
  localparam int MAXW     = FFT_SIZE * 2 * WIDTH;

  logic clk = 1'b0;
  logic rst_n, start, tready;
  logic [FFT_SIZE*WIDTH-1:0] data_r, data_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MAXW-1:0] got, input logic [MAXW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int bitrev(input int v);
    int r, x;
    r = 0;
    x = v;
    for (int n = 0; n < LOG; n++) begin
      r = (r << 1) | (x & 1);
      x = x >> 1;
    end
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int L     = (g == 2 || g == 4) ? 2 : (g == 3) ? 8 : 1;
    localparam int BR    = (g == 1 || g == 4) ? 1 : 0;
    localparam int BEATS = FFT_SIZE / L;

    logic ready, tvalid, tlast, done, err;
    logic [L*2*WIDTH-1:0] tdata;

    fft_stream_out #(.FFT_SIZE(FFT_SIZE), .FFT_SIZE_LOG(LOG), .WIDTH(WIDTH),
                     .LANES(L), .BIT_REVERSE(BR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .data_in_R(data_r), .data_in_I(data_i),
      .ready(ready), .dma_tready(tready), .dma_tvalid(tvalid), .dma_tlast(tlast),
      .dma_tdata(tdata), .frame_done(done), .err_start(err));

    logic [WIDTH-1:0] snap_r [FFT_SIZE];
    logic [WIDTH-1:0] snap_i [FFT_SIZE];
    logic [L*2*WIDTH-1:0] exp_data, prev_data;
    bit   busy, held, m_done, m_err, prev_stall, prev_last, hs, acc;
    int   beat, j;

    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; held = 0; m_done = 0; m_err = 0; beat = 0; prev_stall = 0;
        for (int i = 0; i < FFT_SIZE; i++) begin snap_r[i] = '0; snap_i[i] = '0; end
        check($sformatf("g%0d rst tdata", g), MAXW'(tdata), '0);
      end
      check($sformatf("g%0d ready", g), MAXW'(ready), MAXW'(!busy));
      check($sformatf("g%0d tvalid", g), MAXW'(tvalid), MAXW'(busy));
      check($sformatf("g%0d tlast", g), MAXW'(tlast), MAXW'(busy && beat == BEATS - 1));
      check($sformatf("g%0d frame_done", g), MAXW'(done), MAXW'(m_done));
      check($sformatf("g%0d err_start", g), MAXW'(err), MAXW'(m_err));
      if (busy) begin
        for (int k = 0; k < L; k++) begin
          j = beat * L + k;
          if (BR != 0) j = bitrev(j);
          exp_data[k*2*WIDTH +: 2*WIDTH] = {snap_i[j], snap_r[j]};
        end
        check($sformatf("g%0d tdata b%0d", g, beat), MAXW'(tdata), MAXW'(exp_data));
      end
      if (rst_n && prev_stall) begin
        check($sformatf("g%0d stall tdata", g), MAXW'(tdata), MAXW'(prev_data));
        check($sformatf("g%0d stall tlast", g), MAXW'(tlast), MAXW'(prev_last));
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (rst_n) begin
        hs  = busy && tready;
        acc = start && !busy;
        if (start && busy && !held) m_err = 1;
        held   = acc || (held && start);
        m_done = hs && (beat == BEATS - 1);
        if (acc) begin
          for (int i = 0; i < FFT_SIZE; i++) begin
            snap_r[i] = data_r[i*WIDTH +: WIDTH];
            snap_i[i] = data_i[i*WIDTH +: WIDTH];
          end
          beat = 0;
          busy = 1;
        end else if (hs) begin
          if (beat == BEATS - 1) busy = 0;
          else beat++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < FFT_SIZE; i++) begin
      data_r[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      data_i[i*WIDTH +: WIDTH] = WIDTH'(-(i + 1));
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < FFT_SIZE; i++) begin
      data_r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      data_i[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    rst_n = 1'b0; start = 1'b0; tready = 1'b0; data_r = '0; data_i = '0;
    step();
    do_reset();

    // Ramp frame, full throughput
    set_ramp(); tready = 1'b1;
    step(); start = 1'b1;
    step(); start = 1'b0;
    repeat (12) step();

    // Stalling tready; inputs zeroed after acceptance
    start = 1'b1;
    step(); start = 1'b0; data_r = '0; data_i = '0;
    for (int c = 0; c < 30; c++) begin
      tready = pat[c % 6][0];
      step();
    end
    tready = 1'b1;
    repeat (4) step();

    // Stray start pulse while beat 3 is presented
    set_ramp(); start = 1'b1;
    step(); start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step(); start = 1'b0;
    repeat (10) step();

    // Level start across several frames
    do_reset();
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin set_random(); step(); end
    start = 1'b0;
    repeat (10) step();

    // Free-running random traffic
    for (int c = 0; c < 300; c++) begin
      start  = ($urandom_range(0, 7) == 0);
      tready = ($urandom_range(0, 3) != 0);
      set_random();
      step();
    end
    start = 1'b0; tready = 1'b1;
    repeat (10) step();

    // Asynchronous reset mid-frame, then a clean frame
    do_reset();
    set_ramp(); tready = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("async rst tvalid", MAXW'(inst[0].tvalid), '0);
    check("async rst tlast", MAXW'(inst[0].tlast), '0);
    check("async rst ready", MAXW'(inst[0].ready), MAXW'(1'b1));
    step(); step();
    rst_n = 1'b1;
    set_ramp(); start = 1'b1;
    step(); start = 1'b0;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
